// File: rtl/frame_ram_arbiter_pkg.sv
// Shared types and constants for the frame RAM arbiter.
//   tag_t  : owner of an in-flight RAM read (none / VGA / IPM)
//   mode_t : registered display mode deciding who has priority
package frame_ram_pkg;

  localparam int IMG_W_DEF = 200;
  localparam int IMG_H_DEF = 200;
  localparam int unsigned PIXELS = IMG_W_DEF * IMG_H_DEF;

  typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_IPM} tag_t;
  typedef enum logic       {MODE_ACTIVE, MODE_BLANK}    mode_t;

endpackage

// File: rtl/frame_ram_arbiter_ram_tag_pipe.sv
// RD_LAT-deep shift register of read-owner tags, aligned with the RAM read
// latency so tag_out names the owner of the ram_q word present this cycle.
//   clk, rst_n : clock, async active-low reset (clears to TAG_NONE)
//   tag_in     : owner of the access issued this cycle
//   tag_out    : owner of the access issued RD_LAT cycles ago
module ram_tag_pipe
  import frame_ram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t vld_pipe [RD_LAT:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= RD_LAT; i++) vld_pipe[i] <= TAG_NONE;
    end else begin
      vld_pipe[1] <= tag_in;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign tag_out = vld_pipe[RD_LAT];

endmodule

// File: rtl/frame_ram_arbiter.sv
// Single-port frame RAM arbiter between VGA scan-out and the image-processing
// engine (IPM). One access per clock; read data routed back by tag.
//   vga_*  : pixel fetch (req/addr in, valid/data/miss out)
//   ipm_*  : engine read/write (req held until gnt; rvalid/rdata/err out)
//   ram_*  : RAM macro interface (address/data/wren out, q in)
//   vga_blank : selects priority mode, sampled into a register each clock
module frame_ram_arbiter
  import frame_ram_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_blank,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_miss,
  input  logic              ipm_req,
  input  logic              ipm_we,
  input  logic [ADDR_W-1:0] ipm_addr,
  input  logic [DATA_W-1:0] ipm_wdata,
  output logic              ipm_gnt,
  output logic              ipm_rvalid,
  output logic [DATA_W-1:0] ipm_rdata,
  output logic              ipm_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam longint unsigned PIX = longint'(IMG_W) * longint'(IMG_H);
  localparam int SW = $clog2(STARVE_MAX + 1);

  if (PIX > ((64'd1 << ADDR_W) - 64'd1)) begin : g_bad_size
    $error("IMG_W*IMG_H does not fit in ADDR_W bits");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("RD_LAT must be 1..3");
  end

  mode_t             mode_q;
  logic [SW-1:0]     starve_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] vga_data_q, ipm_data_q;
  logic              err_q;
  logic              ipm_pri, ipm_in_range, vga_win;
  tag_t              tag_in, tag_out;

  assign ipm_in_range = (64'(ipm_addr) < PIX);

  // IPM takes the slot in blanking, when VGA is idle, or once starved.
  // Grants are gated by rst_n so nothing reaches the RAM during reset.
  always_comb begin
    ipm_pri = (mode_q == MODE_BLANK) | ~vga_req | (starve_q == SW'(STARVE_MAX));
    ipm_gnt = rst_n & ipm_req & ipm_pri;
    vga_win = rst_n & vga_req & ~ipm_gnt;
    vga_miss = rst_n & vga_req & ipm_gnt;
    ram_wren = ipm_gnt & ipm_we & ipm_in_range;
    ram_data = ipm_gnt ? ipm_wdata : '0;
    ram_address = addr_q;
    if (vga_win)      ram_address = vga_addr;
    else if (ipm_gnt) ram_address = ipm_addr;
    tag_in = TAG_NONE;
    if (vga_win)                                  tag_in = TAG_VGA;
    else if (ipm_gnt && !ipm_we && ipm_in_range)  tag_in = TAG_IPM;
  end

  ram_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Returned word is visible in the same cycle as its valid pulse, then held.
  assign vga_valid  = (tag_out == TAG_VGA);
  assign ipm_rvalid = (tag_out == TAG_IPM);
  assign vga_data   = vga_valid  ? ram_q : vga_data_q;
  assign ipm_rdata  = ipm_rvalid ? ram_q : ipm_data_q;
  assign ipm_err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_ACTIVE;
      starve_q   <= '0;
      addr_q     <= '0;
      vga_data_q <= '0;
      ipm_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      mode_q <= vga_blank ? MODE_BLANK : MODE_ACTIVE;
      if (ipm_req && !ipm_gnt)
        starve_q <= (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
      else
        starve_q <= '0;
      addr_q <= ram_address;
      if (vga_valid)  vga_data_q <= ram_q;
      if (ipm_rvalid) ipm_data_q <= ram_q;
      if (ipm_gnt && !ipm_in_range) err_q <= 1'b1;
    end
  end

endmodule

// File: doc/frame_ram_arbiter.md
Name: frame_ram_arbiter

Overview:
Shares the single-port 8-bit frame RAM (200x200, 16-bit address) between two requesters: the VGA scan-out fetch and the image-processing engine (read/write). Exactly one RAM access is granted per clock. Read data is returned to the owner of each access after the RAM read latency. Sits between the display pipeline, the processing engine and the RAM macro, and replaces direct engine-to-RAM wiring.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 8, pixel width
IMG_W, 200, image width in pixels
IMG_H, 200, image height in pixels
RD_LAT, 1, RAM clocks from address to q (1..3)
STARVE_MAX, 4, consecutive denied IPM request cycles before IPM is forced a slot

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vga_blank  in  1  1 = display outside the active area
vga_req  in  1  VGA read request, held for one cycle per pixel
vga_addr  in  ADDR_W  VGA pixel address
vga_valid  out  1  VGA read data valid pulse
vga_data  out  DATA_W  VGA read data, held between pulses
vga_miss  out  1  pulse: a VGA request was not served this cycle
ipm_req  in  1  IPM request, held until ipm_gnt
ipm_we  in  1  1 = write, 0 = read
ipm_addr  in  ADDR_W  IPM address
ipm_wdata  in  DATA_W  IPM write data
ipm_gnt  out  1  IPM request accepted this cycle
ipm_rvalid  out  1  IPM read data valid pulse
ipm_rdata  out  DATA_W  IPM read data
ipm_err  out  1  sticky flag: IPM address >= IMG_W*IMG_H was rejected
ram_address  out  ADDR_W  to RAM
ram_data  out  DATA_W  to RAM
ram_wren  out  1  to RAM
ram_q  in  DATA_W  from RAM

Behaviour:
- Reset (async, rst_n=0):
  - mode=ACTIVE, starve counter=0, tag pipeline cleared.
  - vga_valid, vga_miss, ipm_gnt, ipm_rvalid, ipm_err = 0.
  - vga_data, ipm_rdata = 0.
  - ram_wren is forced to 0 while rst_n=0.
- Modes (registered, updated each clock):
  - ACTIVE (vga_blank=0): VGA has priority.
  - BLANK (vga_blank=1): IPM has priority. VGA requests in BLANK are still served when IPM is idle.
- Grant, combinational in cycle N:
  - IPM wins if any of these holds: mode=BLANK; vga_req=0; starve counter==STARVE_MAX.
  - Otherwise VGA wins.
  - ipm_gnt=1 only in the cycle IPM wins with ipm_req=1.
- RAM drive, same cycle as the grant:
  - ram_address, ram_data and ram_wren come from the winner.
  - ram_wren = ipm_we & ipm_gnt.
  - With no winner: ram_wren=0, ram_address holds its last value.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when ipm_req=1 and ipm_gnt=0.
  - Clears on ipm_gnt or when ipm_req=0.
- vga_miss: pulses when vga_req=1 and IPM wins. vga_data holds its previous value; the display repeats the last pixel.
- Out-of-range IPM address (ipm_addr >= IMG_W*IMG_H):
  - ipm_gnt=1 (consumed), ram_wren=0, no ipm_rvalid.
  - ipm_err set; cleared only by reset.
- Read return: an RD_LAT-deep tag pipeline (NONE/VGA/IPM) tracks each read.
  - At N+RD_LAT, the tag selects vga_valid or ipm_rvalid.
  - The matching data register loads ram_q.
  - Writes push tag NONE.
- Simultaneous mode change and request: the grant uses the registered mode (the mode before the edge).
- Reset mid-operation: in-flight tags are discarded and no valid pulses are produced for them.
- Width rule: IMG_W*IMG_H is computed at elaboration and compared against ADDR_W bits unsigned. Elaboration fails if the product does not fit in ADDR_W.

Decomposition:
- Package frame_ram_pkg:
  - tag enum {TAG_NONE, TAG_VGA, TAG_IPM}.
  - mode enum {MODE_ACTIVE, MODE_BLANK}.
  - localparam PIXELS = IMG_W*IMG_H.
- One sub-module, ram_tag_pipe: parameterised RD_LAT shift register of tags, async reset to TAG_NONE.

Test Plan:
- Reset with rst_n=0 mid-read, RD_LAT=1 -> no vga_valid on the following cycle, all outputs 0, ram_wren=0.
- ACTIVE, vga_req=1 at addr 5, RAM holds 0x3C at 5 -> vga_valid and vga_data=0x3C exactly 1 cycle later. ipm_req held meanwhile gets ipm_gnt on the 5th cycle (STARVE_MAX=4), with vga_miss=1 that cycle.
- BLANK, both requesting, IPM write 0xA5 to addr 100 -> ipm_gnt=1, ram_wren=1, ram_address=100, VGA not served. A later IPM read of 100 returns ipm_rdata=0xA5 with ipm_rvalid 1 cycle later.
- IPM write to addr 40000 -> ipm_gnt=1, ram_wren=0, ipm_err=1 and sticky across later traffic.
- RD_LAT=3, alternating VGA/IPM reads every cycle -> each valid pulse arrives 3 cycles after its grant, routed to the correct owner, with no lost or swapped data over 64 accesses.
- vga_blank toggles in the same cycle as requests from both sides -> the grant follows the previous mode, and the new mode applies from the next cycle.
